// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: widths, reset PC default and FSM states.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] HALF_MASK    = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EMIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Thumb instruction fetch: one 32-bit word per request, split into two
// 16-bit halfwords for Decode, with redirect and in-flight discard.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic            req_q;
  logic            valid_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] ipc_q;
  logic [ILEN-1:0] hi_q;

  logic            ack;
  logic [XLEN-1:0] rpc;
  logic [XLEN-1:0] seq_addr;
  logic [XLEN-1:0] tgt_pc;

  // An ack only counts while a request is actually on the bus.
  assign ack      = mem_ack & req_q;
  assign rpc      = redirect_pc & HALF_MASK;
  assign seq_addr = addr_q + 32'd4;
  assign tgt_pc   = redirect ? rpc : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC & WORD_MASK;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      hi_q    <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          req_q <= 1'b1;
          if (redirect) begin
            pc_q <= rpc;
            if (ack || !req_q) begin
              addr_q <= rpc & WORD_MASK;
            end else begin
              state_q <= DISCARD;
            end
          end else if (ack) begin
            state_q <= EMIT;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            hi_q    <= mem_rdata[31:16];
            ipc_q   <= pc_q;
            instr_q <= pc_q[1] ? mem_rdata[31:16]
                               : mem_rdata[15:0];
          end
        end
        EMIT: begin
          if (redirect) begin
            state_q <= FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            pc_q    <= rpc;
            addr_q  <= rpc & WORD_MASK;
          end else if (instr_ready) begin
            if (!ipc_q[1]) begin
              instr_q <= hi_q;
              ipc_q   <= ipc_q + 32'd2;
            end else begin
              state_q <= FETCH;
              valid_q <= 1'b0;
              req_q   <= 1'b1;
              pc_q    <= seq_addr;
              addr_q  <= seq_addr;
            end
          end
        end
        DISCARD: begin
          // Bus stays on the stale address until its ack drains.
          if (redirect) begin
            pc_q <= rpc;
          end
          if (ack) begin
            state_q <= FETCH;
            pc_q    <= tgt_pc;
            addr_q  <= tgt_pc & WORD_MASK;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed corner sequences and a
// randomized run against a halfword-stream reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instruction(instruction),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h1D17_192E;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = word_at(pc & 32'hFFFF_FFFC);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Memory model: ack `lat` cycles after a request is first seen.
  int          lat = 2;
  int          cnt = 0;
  bit          pend = 0;
  logic [31:0] laddr = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0;
      mem_ack = 1'b0;
    end else begin
      if (mem_ack) mem_ack = 1'b0;
      if (pend) begin
        chk("addr_hold", mem_addr, laddr);
        cnt--;
        if (cnt <= 0) begin
          mem_ack = 1'b1;
          mem_rdata = word_at(laddr);
          pend = 0;
        end
      end else if (mem_req) begin
        pend = 1;
        cnt = lat;
        laddr = mem_addr;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic [31:0] pc;
  } vec_t;

  vec_t tab[7];

  initial begin
    bit          ok;
    bit          seen;
    logic [31:0] exp_pc;
    bit          prev_redir;

    tab[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 16'h0000, 32'h0};
    tab[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h0};
    tab[2] = '{1'b1, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h0};
    tab[3] = '{1'b1, 1'b1, 32'h0, 1'b0, 16'h0000, 32'h0};
    tab[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 16'h192E, 32'h0};
    tab[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 16'h1D17, 32'h2};
    tab[6] = '{1'b1, 1'b1, 32'h4, 1'b0, 16'h0000, 32'h0};

    // Reset values and reset-release vector table
    lat = 2;
    #12;
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      instr_ready = tab[i].rdy;
      chk($sformatf("tab%0d_req", i), {31'b0, mem_req},
          {31'b0, tab[i].req});
      chk($sformatf("tab%0d_addr", i), mem_addr, tab[i].addr);
      chk($sformatf("tab%0d_vld", i), {31'b0, instr_valid},
          {31'b0, tab[i].vld});
      if (tab[i].vld) begin
        chk($sformatf("tab%0d_ins", i), {16'h0, instruction},
            {16'h0, tab[i].ins});
        chk($sformatf("tab%0d_pc", i), instr_pc, tab[i].pc);
      end
      tick();
    end

    // Stall for 5 cycles
    do_reset();
    wait_valid(30, ok);
    chk("stall_wait", {31'b0, ok}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ins", {16'h0, instruction}, 32'h0000_192E);
      chk("stall_pc", instr_pc, 32'h0);
      chk("stall_vld", {31'b0, instr_valid}, 32'h1);
      chk("stall_req", {31'b0, mem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    tick();
    chk("stall_next_pc", instr_pc, 32'h2);

    // Redirect in EMIT to an odd halfword
    redirect = 1'b1;
    redirect_pc = 32'h0000_0106;
    tick();
    redirect = 1'b0;
    chk("r106_vld", {31'b0, instr_valid}, 32'h0);
    chk("r106_req", {31'b0, mem_req}, 32'h1);
    chk("r106_addr", mem_addr, 32'h104);
    wait_valid(30, ok);
    chk("r106_wait", {31'b0, ok}, 32'h1);
    chk("r106_pc", instr_pc, 32'h106);
    chk("r106_ins", {16'h0, instruction}, {16'h0, half_at(32'h106)});
    tick();
    chk("r106_next_vld", {31'b0, instr_valid}, 32'h0);
    chk("r106_next_addr", mem_addr, 32'h108);
    chk("r106_next_req", {31'b0, mem_req}, 32'h1);

    // Wrap at top of address space (redirect lands while 0x108 pending)
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    wait_valid(30, ok);
    chk("wrap_wait", {31'b0, ok}, 32'h1);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFE);
    chk("wrap_ins", {16'h0, instruction}, {16'h0, half_at(32'hFFFF_FFFE)});
    tick();
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_req", {31'b0, mem_req}, 32'h1);

    // Redirect during an outstanding 4-cycle request to 0x8
    lat = 4;
    do_reset();
    instr_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (mem_req && mem_addr == 32'h8) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("disc_find8", {31'b0, ok}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    redirect = 1'b0;
    chk("disc_hold_addr", mem_addr, 32'h8);
    chk("disc_hold_req", {31'b0, mem_req}, 32'h1);
    seen = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) seen = 1;
      if (mem_addr == 32'h20) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("disc_req20", {31'b0, ok}, 32'h1);
    chk("disc_no_valid", {31'b0, seen}, 32'h0);
    chk("disc_req20_req", {31'b0, mem_req}, 32'h1);
    wait_valid(30, ok);
    chk("disc_wait", {31'b0, ok}, 32'h1);
    chk("disc_pc", instr_pc, 32'h20);

    // Redirect and handshake in the same cycle
    lat = 2;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(30, ok);
    chk("rh_wait0", {31'b0, ok}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("rh_vld", {31'b0, instr_valid}, 32'h0);
    wait_valid(30, ok);
    chk("rh_wait1", {31'b0, ok}, 32'h1);
    chk("rh_pc", instr_pc, 32'h40);
    chk("rh_ins", {16'h0, instruction}, {16'h0, half_at(32'h40)});

    // Reset pulse mid-request
    lat = 4;
    do_reset();
    wait_valid(30, ok);
    chk("mr_wait0", {31'b0, ok}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    redirect = 1'b0;
    tick();
    chk("mr_pre_addr", mem_addr, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req", {31'b0, mem_req}, 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_vld", {31'b0, instr_valid}, 32'h0);
    chk("mr_ins", {16'h0, instruction}, 32'h0);
    chk("mr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("mr_req1", {31'b0, mem_req}, 32'h1);
    chk("mr_addr1", mem_addr, 32'h0);
    instr_ready = 1'b1;
    wait_valid(30, ok);
    chk("mr_wait1", {31'b0, ok}, 32'h1);
    chk("mr_pc1", instr_pc, 32'h0);
    chk("mr_ins1", {16'h0, instruction}, 32'h0000_192E);

    // Randomized run against the halfword-stream model
    do_reset();
    exp_pc = 32'h0;
    prev_redir = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_redir) chk("rnd_kill", {31'b0, instr_valid}, 32'h0);
      chk("rnd_req_emit", {31'b0, instr_valid & mem_req}, 32'h0);
      lat = int'($urandom_range(1, 4));
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else
        redirect_pc = $urandom & 32'h0000_0FFF;
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFE;
      end else if (instr_valid && instr_ready) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_ins", {16'h0, instruction}, {16'h0, half_at(exp_pc)});
        exp_pc = exp_pc + 32'd2;
      end
      prev_redir = redirect;
      tick();
    end
    redirect = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
